// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the byte-lane helpers used by the extract and merge datapaths.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // A byte lane index times 8 and a halfword lane index times 16 give bit offsets.
  localparam int BYTE_LANE_SHIFT = 3;
  localparam int HALF_LANE_SHIFT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_e;

  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_shift = 5'(addr_lo) << BYTE_LANE_SHIFT;
      SZ_HALF: lane_shift = 5'(addr_lo[1]) << HALF_LANE_SHIFT;
      default: lane_shift = 5'd0;
    endcase
  endfunction

  // Reserved size is reported through the same path as a misaligned access.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_bad_access = 1'b0;
      SZ_HALF: is_bad_access = addr_lo[0];
      SZ_WORD: is_bad_access = |addr_lo;
      default: is_bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and sign/zero-extends a load from a memory
// word, and merges sub-word store data into the old word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ld_result,
  output logic [31:0] st_word
);

  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] lane_mask;

  assign shamt = lane_shift(size, addr_lo);
  assign lane  = ld_word >> shamt;

  // NOTE: every output of a combinational block is assigned on all paths
  // (here via a default arm) so no latch is inferred.
  always_comb begin
    case (size)
      SZ_BYTE: ld_result = {{24{lane[7] & ~is_unsigned}}, lane[7:0]};
      SZ_HALF: ld_result = {{16{lane[15] & ~is_unsigned}}, lane[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: lane_mask = 32'h0000_00ff << shamt;
      SZ_HALF: lane_mask = 32'h0000_ffff << shamt;
      default: lane_mask = 32'hffff_ffff;
    endcase
  end

  // A full-word mask makes the merge collapse to plain store data.
  assign st_word = (st_old & ~lane_mask) | ((st_wdata << shamt) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory; sub-word
// stores use read-modify-write. Optional range check: define LSU_RANGE_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_RANGE_CHECK_EN
  localparam logic RANGE_CHECK_ON = 1'b1;
`else
  localparam logic RANGE_CHECK_ON = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [ADDR_W-1:0] word_idx;
  logic              range_err;
  logic              req_err;
  logic [31:0]       ld_result;
  logic [31:0]       st_word;

  assign word_idx  = {2'b00, req_addr[ADDR_W-1:2]};
  assign range_err = word_idx >= ADDR_W'(MEM_WORDS);
  assign req_err   = is_bad_access(req_size, req_addr[1:0]) | (range_err & RANGE_CHECK_ON);

  lsu_align u_align (
    .ld_word     (mem_rdata),
    .st_old      (merge_q),
    .st_wdata    (wdata_q),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .ld_result   (ld_result),
    .st_word     (st_word)
  );

  always_comb begin
    state_d      = state_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_lo_d  = req_addr[1:0];
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
          mem_addr_d = word_idx;
          if (req_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!req_we) begin
            state_d = ST_LOAD;
          end else if (req_size == SZ_WORD) begin
            state_d  = ST_STORE;
            mem_we_d = 1'b1;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_result;
      end
      ST_STORE, ST_RMW_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end
      ST_RMW_RD: begin
        state_d  = ST_RMW_WR;
        merge_d  = mem_rdata;
        mem_we_d = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // mem_we is a flop with async clear, so reset removes a pending write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_lo_q    <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      merge_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = st_word;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// back-to-back traffic against a byte-level reference model of the memory.
module tb_load_store_unit;

  localparam int MEM_WORDS = 256;
  localparam int ADDR_W    = 32;
  localparam int TB_WORDS  = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Downstream memory: combinational read, write on rising edge, backdoor port.
  logic [31:0] mem     [TB_WORDS];
  logic [31:0] ref_mem [TB_WORDS];
  logic        bd_we = 1'b0;
  logic        bd_clr = 1'b0;
  logic [8:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  assign mem_rdata = mem[mem_addr[8:0]];

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < TB_WORDS; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (mem_we) begin
      mem[mem_addr[8:0]] <= mem_wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Observations of the last transaction.
  int          o_lat, o_wes, o_busy_ready;
  logic        o_err, o_ready0, o_valid0;
  logic [31:0] o_rdata, o_we_addr, o_rdata0;

  // Reference: size -> width, lane byte offset, mask arithmetic on ref_mem.
  function automatic void model_req(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic err, output logic [31:0] rdata,
                                    output int lat, output int wes);
    int          idx;
    int          width;
    int          k;
    logic [31:0] fmask, field, word;
    idx = int'(addr[10:2]);
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`ifdef LSU_RANGE_CHECK_EN
    if ((addr >> 2) >= 32'(MEM_WORDS)) err = 1'b1;
`endif
    rdata = '0;
    lat   = 1;
    wes   = 0;
    if (err) return;
    width = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    k     = (size == 2'd0) ? int'(addr[1:0]) : (size == 2'd1) ? 2 * int'(addr[1]) : 0;
    fmask = (width == 32) ? 32'hffff_ffff : (32'd1 << width) - 32'd1;
    word  = ref_mem[idx];
    if (!we) begin
      field = (word >> (8 * k)) & fmask;
      if (!uns && width < 32 && field[width-1]) field = field | ~fmask;
      rdata = field;
      lat   = 2;
    end else begin
      ref_mem[idx] = (word & ~(fmask << (8 * k))) | ((wdata & fmask) << (8 * k));
      lat = (width == 32) ? 2 : 3;
      wes = 1;
    end
  endfunction

  task automatic bd_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_idx  = 9'(idx);
    bd_data = data;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Issue one request and observe it up to its response (bounded).
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit noise);
    @(negedge clk);
    o_ready0 = req_ready;
    o_valid0 = resp_valid;
    o_rdata0 = resp_rdata;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    o_lat = -1; o_err = 1'b0; o_rdata = '0; o_wes = 0; o_we_addr = '0; o_busy_ready = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_we) begin
        o_wes++;
        o_we_addr = mem_addr;
      end
      if (req_ready) o_busy_ready++;
      if (resp_valid) begin
        o_lat   = c;
        o_err   = resp_err;
        o_rdata = resp_rdata;
        break;
      end
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
        req_size = 2'($urandom_range(0, 3)); req_addr = $urandom; req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bd_clr = 1'b1;
    repeat (3) @(negedge clk);
    bd_clr = 1'b0;
    for (int i = 0; i < TB_WORDS; i++) ref_mem[i] = '0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_store_load;
    logic e; logic [31:0] r; int l, w;
    model_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hdead_beef, e, r, l, w);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hdead_beef, 1'b0);
    n_checks++; if (o_lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", o_lat); end
    n_checks++; if (o_wes !== 1) begin n_fail++; $display("FAIL sw_we_cycles: got %0d want 1", o_wes); end
    n_checks++; if (o_we_addr !== 32'h4) begin n_fail++; $display("FAIL sw_mem_addr: got %h want 4", o_we_addr); end
    n_checks++; if (o_err !== 1'b0 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_resp: got err=%b rdata=%h want 0/0", o_err, o_rdata); end
    n_checks++; if (mem[4] !== 32'hdead_beef) begin n_fail++; $display("FAIL sw_mem_word: got %h want deadbeef", mem[4]); end
    model_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, r, l, w);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    n_checks++; if (o_lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", o_lat); end
    n_checks++; if (o_rdata !== 32'hdead_beef || o_err !== 1'b0) begin n_fail++; $display("FAIL lw_rdata: got %h err=%b want deadbeef err=0", o_rdata, o_err); end
  endtask

  task automatic test_sub_word_load;
    logic [31:0] addrs [5] = '{32'h13, 32'h13, 32'h11, 32'h12, 32'h12};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [5] = '{32'hffff_ff80, 32'h0000_0080, 32'h0000_007f, 32'hffff_80ff, 32'h0000_80ff};
    bd_write(4, 32'h80ff_7f01);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, 1'b0);
      n_checks++;
      if (o_rdata !== exps[i] || o_err !== 1'b0 || o_lat !== 2) begin
        n_fail++;
        $display("FAIL subword_load_%0d: got rdata=%h err=%b lat=%0d want %h/0/2", i, o_rdata, o_err, o_lat, exps[i]);
      end
    end
  endtask

  task automatic test_rmw_store;
    logic e; logic [31:0] r; int l, w;
    bd_write(2, 32'h1122_3344);
    model_req(1'b1, 2'b01, 1'b0, 32'h0a, 32'h0000_abcd, e, r, l, w);
    do_req(1'b1, 2'b01, 1'b0, 32'h0a, 32'h0000_abcd, 1'b0);
    n_checks++; if (o_lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", o_lat); end
    n_checks++; if (o_wes !== 1 || o_we_addr !== 32'h2) begin n_fail++; $display("FAIL sh_write: got %0d cycles at %h want 1 at 2", o_wes, o_we_addr); end
    n_checks++; if (mem[2] !== 32'habcd_3344) begin n_fail++; $display("FAIL sh_mem_word: got %h want abcd3344", mem[2]); end
    model_req(1'b1, 2'b00, 1'b0, 32'h09, 32'hffff_ff55, e, r, l, w);
    do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'hffff_ff55, 1'b0);
    n_checks++; if (mem[2] !== 32'habcd_5544 || o_lat !== 3) begin n_fail++; $display("FAIL sb_mem_word: got %h lat=%0d want abcd5544 lat=3", mem[2], o_lat); end
  endtask

  task automatic test_misaligned;
    logic        wes  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  szs  [4] = '{2'b10, 2'b01, 2'b11, 2'b11};
    logic [31:0] adrs [4] = '{32'h06, 32'h03, 32'h08, 32'h0c};
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_req(wes[i], szs[i], 1'b0, adrs[i], 32'hffff_1234, 1'b0);
      n_checks++;
      if (o_err !== 1'b1 || o_lat !== 1 || o_rdata !== 32'h0 || o_wes !== 0) begin
        n_fail++;
        $display("FAIL misaligned_%0d: got err=%b lat=%0d rdata=%h we=%0d want 1/1/0/0", i, o_err, o_lat, o_rdata, o_wes);
      end
      n_checks++;
      if (mem[adrs[i][10:2]] !== ref_mem[adrs[i][10:2]]) begin
        n_fail++;
        $display("FAIL misaligned_mem_%0d: got %h want %h", i, mem[adrs[i][10:2]], ref_mem[adrs[i][10:2]]);
      end
    end
  endtask

  task automatic test_range;
    logic e; logic [31:0] r; int l, w;
    model_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h0bad_f00d, e, r, l, w);
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h0bad_f00d, 1'b0);
`ifdef LSU_RANGE_CHECK_EN
    n_checks++; if (o_err !== 1'b1 || o_lat !== 1 || o_wes !== 0) begin n_fail++; $display("FAIL range_err: got err=%b lat=%0d we=%0d want 1/1/0", o_err, o_lat, o_wes); end
    n_checks++; if (mem[256] !== 32'h0) begin n_fail++; $display("FAIL range_mem: got %h want 0", mem[256]); end
`else
    n_checks++; if (o_err !== 1'b0 || o_wes !== 1 || o_we_addr !== 32'h100) begin n_fail++; $display("FAIL range_pass: got err=%b we=%0d addr=%h want 0/1/100", o_err, o_wes, o_we_addr); end
    n_checks++; if (mem[256] !== 32'h0bad_f00d) begin n_fail++; $display("FAIL range_mem: got %h want 0badf00d", mem[256]); end
`endif
  endtask

  task automatic test_reset_abort;
    int we_seen;
    bd_write(0, 32'h1234_5678);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0000_00aa;
    @(negedge clk);
    req_valid = 1'b0;
    we_seen = int'(mem_we);
    rst_n = 1'b0;
    #1;
    we_seen += int'(mem_we);
    repeat (2) begin @(negedge clk); we_seen += int'(mem_we); end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); we_seen += int'(mem_we); end
    n_checks++; if (we_seen !== 0) begin n_fail++; $display("FAIL abort_rmw_we: got %0d write cycles want 0", we_seen); end
    n_checks++; if (mem[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL abort_rmw_mem: got %h want 12345678", mem[0]); end
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rmw_ready: got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
    // Word store aborted while its write enable is already high.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h4; req_wdata = 32'hcafe_f00d;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL abort_store_we_pre: got %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_store_we_async: got %b want 0", mem_we); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (mem[1] !== ref_mem[1]) begin n_fail++; $display("FAIL abort_store_mem: got %h want %h", mem[1], ref_mem[1]); end
  endtask

  task automatic test_random_back_to_back;
    logic        we, uns, e;
    logic [1:0]  size;
    logic [31:0] addr, wdata, r, last_rdata;
    int          l, w, idx;
    last_rdata = '0;
    for (int i = 0; i < 16; i++) bd_write(i, $urandom);
    for (int t = 0; t < 150; t++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      idx   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 15));
      addr  = 32'(idx * 4) + 32'($urandom_range(0, 3));
      wdata = $urandom;
      model_req(we, size, uns, addr, wdata, e, r, l, w);
      do_req(we, size, uns, addr, wdata, 1'b1);
      n_checks++;
      if (o_ready0 !== 1'b1 || o_valid0 !== 1'b0 || o_rdata0 !== last_rdata) begin
        n_fail++;
        $display("FAIL rnd_idle_%0d: got ready=%b valid=%b rdata=%h want 1/0/%h", t, o_ready0, o_valid0, o_rdata0, last_rdata);
      end
      n_checks++;
      if (o_lat !== l || o_err !== e || o_rdata !== r) begin
        n_fail++;
        $display("FAIL rnd_resp_%0d: got lat=%0d err=%b rdata=%h want %0d/%b/%h (we=%b sz=%0d a=%h)", t, o_lat, o_err, o_rdata, l, e, r, we, size, addr);
      end
      n_checks++;
      if (o_wes !== w || (w == 1 && o_we_addr !== 32'(idx)) || o_busy_ready !== 0) begin
        n_fail++;
        $display("FAIL rnd_mem_if_%0d: got we=%0d addr=%h busy_ready=%0d want %0d/%h/0", t, o_wes, o_we_addr, o_busy_ready, w, idx);
      end
      n_checks++;
      if (mem[idx] !== ref_mem[idx]) begin
        n_fail++;
        $display("FAIL rnd_mem_word_%0d: got %h want %h at word %0d", t, mem[idx], ref_mem[idx], idx);
      end
      last_rdata = r;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_store_load();
    test_sub_word_load();
    test_rmw_store();
    test_misaligned();
    test_range();
    test_reset_abort();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory, between the execute stage (ALU address, rs2 data) and that memory.
- Converts byte, halfword and word load/store requests into word accesses.
- Sub-word stores use read-modify-write.
- Loads return an aligned, sign- or zero-extended result to writeback; misaligned accesses are flagged.

Parameters:
- MEM_WORDS, 256, depth of the downstream memory in 32-bit words; used by the range check.
- ADDR_W, 32, width of the byte address and of mem_addr.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend load result when 1.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  32  store data; LSBs hold the sub-word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualified by resp_valid; misaligned, reserved size or out of range.
- resp_rdata  out  32  load result, qualified by resp_valid.
- mem_we  out  1  memory write enable, sampled by memory on the rising edge.
- mem_addr  out  ADDR_W  word index = {2'b00, addr[ADDR_W-1:2]}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=1 after release; resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal address, data and merge registers cleared.
- Handshake: req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid&req_ready; all request fields are registered then. There is no response backpressure.
- Alignment checks:
  - Half is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
  - Byte is always aligned.
  - Size 11 is an error.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE on accept:
  - Error → RESP with err=1.
  - Load → LOAD.
  - Word store → STORE.
  - Byte/half store → RMW_RD.
- LOAD:
  - mem_addr = registered word index; mem_we=0.
  - At the edge, register the extracted lane. Byte lane is addr[1:0]*8; half lane is addr[1]*16.
  - Sign-extend unless unsigned; word passes through. → RESP.
- STORE: mem_we=1, mem_wdata=req_wdata. → RESP.
- RMW_RD: mem_we=0. At the edge, capture mem_rdata into the merge register. → RMW_WR.
- RMW_WR: mem_we=1, mem_wdata = merge with the target lane replaced by wdata[7:0] or wdata[15:0]. → RESP.
- RESP: resp_valid=1 for exactly one cycle. → IDLE; a new request is accepted the cycle after.
- Latency, accept edge to resp_valid:
  - Load / word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Outputs outside the states above:
  - mem_we=0 outside STORE/RMW_WR.
  - resp_rdata holds its last value and is forced to 0 on error and on stores.
- Errored requests never assert mem_we.
- Reset mid-operation aborts immediately; mem_we drops asynchronously. If reset asserts before the RMW_WR edge, memory is unchanged.
- req_valid may change freely while req_ready=0 and is ignored.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: an accepted request with addr[ADDR_W-1:2] >= MEM_WORDS takes the error path (resp_err=1, no memory access, 1-cycle latency).
- Undefined: no range check; the word index is driven unchanged and out-of-range behaviour is the memory's.

Decomposition:
- Package lsu_pkg holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The FSM state enum.
  - Lane-shift helper constants.
- One natural combinational sub-module, lsu_align:
  - Load extract/extend: word, addr[1:0], size, unsigned → result.
  - Store merge: old word, wdata, addr[1:0], size → new word.

Test Plan:
- Word store then load: store addr 0x10, wdata 0xDEADBEEF → mem_addr=0x4, mem_we high exactly one cycle, resp 2 cycles after accept. Then load word at 0x10 → resp_rdata=0xDEADBEEF, err=0.
- Byte load sign/zero: memory word 4 = 0x80FF7F01.
  - lb at 0x13 → 0xFFFFFF80.
  - lbu at 0x13 → 0x00000080.
  - lb at 0x11 → 0x0000007F.
- Sub-word RMW: memory word 2 = 0x11223344; sh at 0x0A with wdata 0x0000ABCD → RMW_RD then RMW_WR, memory word 2 = 0xABCD3344, resp 3 cycles after accept.
- Misaligned: lw at 0x06, sh at 0x03, size 11 → resp_err=1 one cycle after accept, resp_rdata=0, mem_we never asserted, memory unchanged.
- Reset mid-RMW: sb at 0x00 with wdata 0xAA; drop rst_n during RMW_RD → mem_we stays 0, memory word 0 unchanged, req_ready=1 after release.
- Range check (LSU_RANGE_CHECK_EN, MEM_WORDS=256): sw at 0x400 → resp_err=1, no write. Without the macro: mem_addr=0x100, mem_we pulses.
